// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - round-robin arbiter feeding frame headers and payload bytes to a single MAC TX path
module tx_frame_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int LEN_W          = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*48-1:0]    req_dest_mac,
    input  logic [NUM_REQ*48-1:0]    req_src_mac,
    input  logic [NUM_REQ*16-1:0]    req_eth_type,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     req_data,
    input  logic [NUM_REQ-1:0]       req_empty,
    output logic [NUM_REQ-1:0]       req_rd,
    output logic [NUM_REQ-1:0]       grant,
    output logic [47:0]              app_tx_dest_mac,
    output logic [47:0]              app_tx_src_mac,
    output logic [15:0]              app_tx_eth_type,
    output logic                     app_tx_start,
    output logic [7:0]               app_tx_data,
    output logic                     app_tx_data_valid,
    input  logic                     tx_fifo_full,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     tx_timeout,
    output logic                     len_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_START,
        S_STREAM,
        S_WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [47:0]        dest_q, dest_d;
    logic [47:0]        src_q, src_d;
    logic [15:0]        type_q, type_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [IDX_W-1:0]   pick;
    logic               pick_vld;

    // Descending scan so the requester nearest after last_q is the final (winning) write.
    always_comb begin : rr_pick
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (req_valid[cand_idx]) begin
                pick     = cand_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            dest_q  <= '0;
            src_q   <= '0;
            type_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            type_q  <= type_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        idx_d             = idx_q;
        last_d            = last_q;
        dest_d            = dest_q;
        src_d             = src_q;
        type_d            = type_q;
        len_d             = len_q;
        cnt_d             = cnt_q;
        tmo_d             = tmo_q;
        req_rd            = '0;
        app_tx_data       = '0;
        app_tx_data_valid = 1'b0;
        app_tx_start      = 1'b0;
        tx_timeout        = 1'b0;
        len_err           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = NUM_REQ'(1) << pick;
                    idx_d   = pick;
                    dest_d  = req_dest_mac[pick*48 +: 48];
                    src_d   = req_src_mac[pick*48 +: 48];
                    type_d  = req_eth_type[pick*16 +: 16];
                    len_d   = req_len[pick*LEN_W +: LEN_W];
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (len_q == '0) begin
                    len_err = 1'b1;
                    grant_d = '0;
                    last_d  = idx_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                app_tx_start = 1'b1;
                state_d      = S_STREAM;
            end
            S_STREAM: begin
                if (!tx_fifo_full && !req_empty[idx_q]) begin
                    req_rd            = grant_q;
                    app_tx_data       = req_data[idx_q*8 +: 8];
                    app_tx_data_valid = 1'b1;
                    // Compare against len-1 so the maximum length never needs a wider counter.
                    if (cnt_q == len_q - 1'b1) begin
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = S_WAIT_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + 1'b1;
                if (tx_done) begin
                    grant_d = '0;
                    last_d  = idx_q;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tx_timeout = 1'b1;
                    grant_d    = '0;
                    last_d     = idx_q;
                    tmo_d      = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant           = grant_q;
    assign app_tx_dest_mac = dest_q;
    assign app_tx_src_mac  = src_q;
    assign app_tx_eth_type = type_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - randomized bench for tx_frame_arbiter against a frame-level reference model
module tb_tx_frame_arbiter;

    localparam int N   = 2;
    localparam int LW  = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*48-1:0] req_dest_mac;
    logic [N*48-1:0] req_src_mac;
    logic [N*16-1:0] req_eth_type;
    logic [N*LW-1:0] req_len;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    req_empty;
    logic [N-1:0]    req_rd;
    logic [N-1:0]    grant;
    logic [47:0]     app_tx_dest_mac;
    logic [47:0]     app_tx_src_mac;
    logic [15:0]     app_tx_eth_type;
    logic            app_tx_start;
    logic [7:0]      app_tx_data;
    logic            app_tx_data_valid;
    logic            tx_fifo_full;
    logic            tx_done;
    logic            busy;
    logic            tx_timeout;
    logic            len_err;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_dest_mac(req_dest_mac), .req_src_mac(req_src_mac),
        .req_eth_type(req_eth_type), .req_len(req_len), .req_data(req_data),
        .req_empty(req_empty), .req_rd(req_rd), .grant(grant),
        .app_tx_dest_mac(app_tx_dest_mac), .app_tx_src_mac(app_tx_src_mac),
        .app_tx_eth_type(app_tx_eth_type), .app_tx_start(app_tx_start),
        .app_tx_data(app_tx_data), .app_tx_data_valid(app_tx_data_valid),
        .tx_fifo_full(tx_fifo_full), .tx_done(tx_done), .busy(busy),
        .tx_timeout(tx_timeout), .len_err(len_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Requester buffers, the bench's own copy of expected bytes, and pending frame lengths.
    logic [7:0]  buf_q [N][$];
    logic [7:0]  exp_q [N][$];
    int          pend_len [N][$];
    logic [47:0] hd_dest [N];
    logic [47:0] hd_src [N];
    logic [15:0] hd_type [N];
    bit          head_pop [N];

    logic [N-1:0]    prev_valid;
    logic [N*LW-1:0] prev_len;
    logic [N*48-1:0] prev_dest, prev_src;
    logic [N*16-1:0] prev_type;
    logic [N-1:0]    rd_s;

    int cyc = 0;
    int m_last = N - 1;
    bit active = 0;
    int m_w, m_len, m_beats, grant_cyc, last_beat_cyc, done_cyc;
    logic [47:0] m_dest, m_src;
    logic [15:0] m_type;
    bit tmo_seen;
    bit done_mode = 1;
    int done_cnt = -1;
    int full_pct = 0, empty_pct = 0;
    int starts = 0, len_errs = 0, timeouts = 0;
    int win_log [$];

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pend_len[i].size();
        return s;
    endfunction

    task automatic new_header(input int i);
        hd_dest[i] = 48'({$urandom(), $urandom()});
        hd_src[i]  = 48'({$urandom(), $urandom()});
        hd_type[i] = 16'($urandom());
    endtask

    task automatic add_frame(input int i, input int len, input bit fixed);
        for (int j = 0; j < len; j++) begin
            logic [7:0] b;
            b = fixed ? 8'(8'hA1 + j) : 8'($urandom());
            buf_q[i].push_back(b);
            exp_q[i].push_back(b);
        end
        pend_len[i].push_back(len);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rd_s[i] && buf_q[i].size() > 0) void'(buf_q[i].pop_front());
            if (head_pop[i]) begin
                if (pend_len[i].size() > 0) void'(pend_len[i].pop_front());
                new_header(i);
                head_pop[i] = 0;
            end
            req_valid[i]             = (pend_len[i].size() > 0);
            req_len[i*LW +: LW]      = (pend_len[i].size() > 0) ? LW'(pend_len[i][0]) : '0;
            req_dest_mac[i*48 +: 48] = hd_dest[i];
            req_src_mac[i*48 +: 48]  = hd_src[i];
            req_eth_type[i*16 +: 16] = hd_type[i];
            req_empty[i]             = (buf_q[i].size() == 0) || ($urandom_range(99) < empty_pct);
            req_data[i*8 +: 8]       = (buf_q[i].size() > 0) ? buf_q[i][0] : 8'h00;
        end
        rd_s         = '0;
        tx_fifo_full = ($urandom_range(99) < full_pct);
        tx_done      = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                tx_done  = 1'b1;
                done_cyc = cyc + 1;
                done_cnt = -1;
            end
        end else if (done_mode && active && m_len > 0 && m_beats < m_len && $urandom_range(9) == 0) begin
            tx_done = 1'b1;
        end
    endtask

    task automatic sample();
        int w;
        logic [7:0] eb;
        @(negedge clk);
        cyc++;
        rd_s = req_rd;
        check_eq("onehot", 64'($onehot0(grant) && $onehot0(req_rd)), 1);
        if (!active && grant != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && prev_valid[(m_last + k) % N]) w = (m_last + k) % N;
            if (w < 0) begin
                check_eq("grant_unrequested", grant, 0);
                w = 0;
            end else begin
                check_eq("grant", grant, N'(1) << w);
            end
            m_w    = w;
            m_len  = int'(prev_len[w*LW +: LW]);
            m_dest = prev_dest[w*48 +: 48];
            m_src  = prev_src[w*48 +: 48];
            m_type = prev_type[w*16 +: 16];
            check_eq("hdr_dest", app_tx_dest_mac, m_dest);
            check_eq("hdr_src", app_tx_src_mac, m_src);
            check_eq("hdr_type", app_tx_eth_type, m_type);
            check_eq("len_err", len_err, m_len == 0);
            check_eq("busy_on", busy, 1);
            active = 1; m_beats = 0; grant_cyc = cyc; tmo_seen = 0;
            head_pop[w] = 1;
            win_log.push_back(w);
            if (len_err) len_errs++;
        end else if (active && grant == '0) begin
            check_eq("beats", m_beats, m_len);
            check_eq("busy_off", busy, 0);
            if (m_len != 0) begin
                if (done_mode) check_eq("done_lat", cyc - done_cyc, 1);
                else check_eq("tmo_seen", tmo_seen, 1);
            end
            m_last = m_w;
            active = 0;
        end else begin
            if (active) begin
                check_eq("grant_hold", grant, N'(1) << m_w);
                check_eq("hdr_hold", app_tx_dest_mac, m_dest);
            end
            check_eq("len_err_stray", len_err, 0);
        end
        if (app_tx_start) begin
            starts++;
            check_eq("start_lat", cyc - grant_cyc, 1);
            check_eq("start_nonzero", m_len != 0, 1);
        end
        if (app_tx_data_valid || req_rd != '0) begin
            check_eq("rd_vs_valid", req_rd, app_tx_data_valid ? (N'(1) << m_w) : '0);
            check_eq("no_stall", {tx_fifo_full, req_empty[m_w]}, 0);
            eb = 8'hxx;
            if (exp_q[m_w].size() > 0) eb = exp_q[m_w].pop_front();
            check_eq("data", app_tx_data, eb);
            m_beats++;
            last_beat_cyc = cyc;
            if (m_beats == m_len && done_mode) done_cnt = $urandom_range(5, 1);
        end
        if (tx_timeout) begin
            timeouts++;
            tmo_seen = 1;
            check_eq("tmo_lat", cyc - last_beat_cyc, TMO);
            check_eq("tmo_unexpected", done_mode, 0);
        end
        prev_valid = req_valid;
        prev_len   = req_len;
        prev_dest  = req_dest_mac;
        prev_src   = req_src_mac;
        prev_type  = req_eth_type;
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (pending() > 0 || active || busy); n++) tick();
        check_eq("drain", 64'(pending() > 0 || active || busy), 0);
        repeat (2) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {grant, req_rd, app_tx_start, app_tx_data_valid, app_tx_data,
                       busy, tx_timeout, len_err}, 0);
        check_eq({tag, "_hdr"}, {app_tx_dest_mac, app_tx_eth_type}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int s0, l0, t0, w0;
        for (int i = 0; i < N; i++) begin new_header(i); head_pop[i] = 0; end
        rd_s = '0;
        prev_valid = '0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single frame, no stalls
        done_mode = 1; full_pct = 0; empty_pct = 0;
        s0 = starts;
        add_frame(0, 4, 1);
        drain(200);
        check_eq("single_starts", starts - s0, 1);

        // round-robin, both requesters continuously pending; last owner was 0
        win_log.delete();
        add_frame(0, 3, 0); add_frame(0, 3, 0);
        add_frame(1, 3, 0); add_frame(1, 3, 0);
        drain(400);
        check_eq("rr_count", win_log.size(), 4);
        if (win_log.size() == 4)
            check_eq("rr_order", {4'(win_log[0]), 4'(win_log[1]), 4'(win_log[2]), 4'(win_log[3])},
                     16'h1010);

        // randomized backpressure and empty stalls, including maximum length
        full_pct = 30; empty_pct = 25;
        add_frame(0, 6, 0);
        add_frame(1, 15, 0);
        drain(800);
        full_pct = 0; empty_pct = 0;

        // timeout: MAC never completes
        done_mode = 0;
        t0 = timeouts;
        win_log.delete();
        add_frame(0, 3, 0); add_frame(1, 3, 0);
        drain(400);
        check_eq("tmo_count", timeouts - t0, 2);
        if (win_log.size() == 2) check_eq("tmo_moves", win_log[0] != win_log[1], 1);
        done_mode = 1;

        // zero length request is dropped, the other is serviced
        s0 = starts; l0 = len_errs;
        add_frame(0, 0, 0); add_frame(1, 2, 0);
        drain(200);
        check_eq("zero_len_err", len_errs - l0, 1);
        check_eq("zero_len_starts", starts - s0, 1);

        // reset mid-stream
        add_frame(0, 8, 0); add_frame(1, 8, 0);
        for (int n = 0; n < 100 && !(active && m_beats >= 2); n++) tick();
        check_eq("pre_reset_beats", m_beats, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        for (int i = 0; i < N; i++) begin
            buf_q[i].delete(); exp_q[i].delete(); pend_len[i].delete(); head_pop[i] = 0;
        end
        active = 0; m_last = N - 1; done_cnt = -1; prev_valid = '0; rd_s = '0;
        drive_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        win_log.delete();
        add_frame(0, 3, 0); add_frame(1, 3, 0);
        drain(300);
        w0 = (win_log.size() > 0) ? win_log[0] : -1;
        check_eq("post_reset_first", w0, 0);

        // random mix
        full_pct = 20; empty_pct = 15;
        for (int f = 0; f < 16; f++) add_frame($urandom_range(N - 1), $urandom_range(15, 0), 0);
        drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
